sid_envelope: RTL and testbench
===============================

// Module: sid_envelope
// PURPOSE
// - ADSR envelope generator for one SID voice, modelled on the MOS 6581 envelope.
// - Decodes its three voice registers from the shared SID write bus.
// - Produces an 8-bit unsigned amplitude that drives that voice's multiplying DAC.
// - The sid top instantiates three copies, one per voice, at BASE_ADDR 0x00, 0x07 and 0x0E.
// PARAMETERS
// - BASE_ADDR   5'h00   First register address of the owning voice.
//   - CTRL = BASE+4, AD = BASE+5, SR = BASE+6.
// PORTS
// - CLK     in   1  Master clock. Sole clock domain.
// - RST     in   1  Synchronous reset, active-high.
// - CLKen   in   1  1 MHz enable. All envelope timing counts CLKen cycles.
// - WR      in   1  Register write strobe, sampled on every CLK (ignores CLKen).
// - ADDR    in   5  SID register address.
// - DATA    in   8  Write data.
// - OUTPUT  out  8  Envelope level, registered, unsigned 0x00..0xFF.
// BEHAVIOUR
// - Reset: all registers 0, state=RELEASE, env=0, rate_cnt=0, exp_cnt=0.
//   - OUTPUT=0x00 the cycle after RST is sampled high. RST overrides WR and CLKen.
// - Register writes: on WR && ADDR==BASE+n, capture DATA.
//   - CTRL: bit0 = gate; other bits ignored.
//   - AD: attack = [7:4], decay = [3:0].
//   - SR: sustain = [7:4], release = [3:0].
//   - Addresses outside BASE+4..BASE+6 are ignored.
//   - A new value takes effect from the next CLK.
// - Gate edges: detected from the stored gate bit vs. its previous value, evaluated every CLK.
//   - 0->1: state=ATTACK.
//   - 1->0: state=RELEASE.
//   - env is never reset on a gate edge.
// - Advance: the items below happen only on CLK edges with CLKen=1.
// - Rate counter: 15-bit rate_cnt increments each CLKen.
//   - When rate_cnt==period-1: rate_cnt<=0 and a rate tick fires.
//   - Period comes from the active nibble (attack, decay or release, by state).
//   - Nibble -> period: 9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907, 11720, 19532, 31251.
//   - rate_cnt is free-running. It is not cleared on state or nibble change.
//   - If a rate change leaves rate_cnt >= period-1, the counter runs on to 0x7FFF, wraps to 0, then matches.
// - ATTACK: each rate tick does env+1, linear, with no exponential divider.
//   - When env reaches 0xFF: state=DECAY_SUSTAIN, taking effect the same edge that sets 0xFF.
// - DECAY_SUSTAIN:
//   - Sustain level = {sustain, sustain} (e.g. 0x8 -> 0x88).
//   - On an exp tick with env > level: env-1.
//   - Once env == level, env holds.
//   - env < level (sustain raised later) also holds; env never climbs in this state.
// - RELEASE: on each exp tick with env > 0: env-1.
//   - Holds at 0x00; never wraps to 0xFF.
// - Exponential divider (DECAY_SUSTAIN and RELEASE):
//   - exp_cnt counts rate ticks.
//   - An exp tick fires when exp_cnt+1 == exp_period; exp_cnt then returns to 0.
//   - exp_period by current env:
//     - 0x5E..0xFF: 1
//     - 0x37..0x5D: 2
//     - 0x1B..0x36: 4
//     - 0x0F..0x1A: 8
//     - 0x07..0x0E: 16
//     - 0x01..0x06: 30
//     - 0x00: 1
//   - exp_cnt clears on entry to ATTACK.
// - OUTPUT == env register. It updates on the same CLK edge as the tick; no extra latency.
// - CLKen=0: env, rate_cnt and exp_cnt frozen. Register writes and gate edges are still accepted.
// TESTING
// - Attack to full:
//   - Stimulus: RST, then AD=0x00, SR=0xF0, CTRL=0x01, CLKen every 4th CLK.
//   - Response: OUTPUT reaches 0xFF after exactly 2295 CLKen pulses, then holds 0xFF (sustain 0xFF).
// - Decay to sustain: AD=0x00, SR=0x80, gate on.
//   - Response: OUTPUT climbs to 0xFF, falls to 0x88, then stays 0x88 for more than 10000 CLKen.
// - Release floor: from 0x88 write CTRL=0x00 with release 0.
//   - Response: OUTPUT decreases monotonically to 0x00 and never wraps.
//   - Response: first step after 0x5E->0x5D takes 2 rate ticks.
// - Reset mid-attack: assert RST with OUTPUT=0x40.
//   - Response: OUTPUT=0x00 the next CLK.
//   - Response: a new gate 0->1 restarts attack from 0.
// - Address decode, BASE_ADDR=0x07:
//   - Writes to 0x04..0x06 leave OUTPUT=0 regardless of CLKen.
//   - Writes to 0x0B..0x0D control the envelope.
// - Enable gating: hold CLKen=0 during attack.
//   - Response: OUTPUT constant. Resuming CLKen continues from the same value with no lost ticks.

Source files
------------

// File: rtl/sid_envelope.sv
// sid_envelope -- ADSR envelope generator for one SID voice (6581 style).
// Decodes CTRL/AD/SR at BASE_ADDR+4..+6 from the shared write bus and
// produces an 8-bit amplitude for the voice's multiplying DAC.
// Ports:
//   CLK    master clock (single domain)
//   RST    synchronous reset, active high; overrides WR and CLKen
//   CLKen  1 MHz advance enable; all envelope timing counts these
//   WR     register write strobe, sampled every CLK
//   ADDR   SID register address
//   DATA   write data
//   OUTPUT envelope level (the env register itself, no extra latency)
module sid_envelope #(
  parameter logic [4:0] BASE_ADDR = 5'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLKen,
  input  logic       WR,
  input  logic [4:0] ADDR,
  input  logic [7:0] DATA,
  output logic [7:0] OUTPUT
);

  localparam logic [4:0] CTRL_ADDR = BASE_ADDR + 5'd4;
  localparam logic [4:0] AD_ADDR   = BASE_ADDR + 5'd5;
  localparam logic [4:0] SR_ADDR   = BASE_ADDR + 5'd6;

  typedef enum logic [1:0] {
    ATTACK,
    DECAY_SUSTAIN,
    RELEASE
  } state_t;

  state_t      state, state_nx;
  logic        gate, gate_q;
  logic [3:0]  atk, dcy, sus, rel;
  logic [7:0]  env, env_nx;
  logic [14:0] rate_cnt, rate_nx;
  logic [4:0]  exp_cnt, exp_nx;

  logic [3:0]  rate_nib;
  logic [14:0] period_m1;
  logic        rate_tick, exp_tick;
  logic [4:0]  exp_period;
  logic [7:0]  sus_level;
  logic        gate_rise, gate_fall;

  // Rate nibble -> (period - 1) in CLKen cycles.
  function automatic logic [14:0] rate_lut(input logic [3:0] nib);
    case (nib)
      4'h0: rate_lut = 15'd8;
      4'h1: rate_lut = 15'd31;
      4'h2: rate_lut = 15'd62;
      4'h3: rate_lut = 15'd94;
      4'h4: rate_lut = 15'd148;
      4'h5: rate_lut = 15'd219;
      4'h6: rate_lut = 15'd266;
      4'h7: rate_lut = 15'd312;
      4'h8: rate_lut = 15'd391;
      4'h9: rate_lut = 15'd976;
      4'hA: rate_lut = 15'd1953;
      4'hB: rate_lut = 15'd3125;
      4'hC: rate_lut = 15'd3906;
      4'hD: rate_lut = 15'd11719;
      4'hE: rate_lut = 15'd19531;
      default: rate_lut = 15'd31250;
    endcase
  endfunction

  // Piecewise-exponential slope: lower levels step less often.
  function automatic logic [4:0] exp_lut(input logic [7:0] lvl);
    if (lvl >= 8'h5E)      exp_lut = 5'd1;
    else if (lvl >= 8'h37) exp_lut = 5'd2;
    else if (lvl >= 8'h1B) exp_lut = 5'd4;
    else if (lvl >= 8'h0F) exp_lut = 5'd8;
    else if (lvl >= 8'h07) exp_lut = 5'd16;
    else if (lvl >= 8'h01) exp_lut = 5'd30;
    else                   exp_lut = 5'd1;
  endfunction

  assign gate_rise = gate & ~gate_q;
  assign gate_fall = ~gate & gate_q;
  assign sus_level = {sus, sus};
  assign OUTPUT    = env;

  always_comb begin
    case (state)
      ATTACK:        rate_nib = atk;
      DECAY_SUSTAIN: rate_nib = dcy;
      default:       rate_nib = rel;
    endcase
  end

  assign period_m1  = rate_lut(rate_nib);
  // Free-running: if the period shrank below the count, it wraps at 0x7FFF.
  assign rate_tick  = (rate_cnt == period_m1);
  assign rate_nx    = rate_tick ? 15'd0 : rate_cnt + 15'd1;
  assign exp_period = exp_lut(env);
  assign exp_tick   = rate_tick && ((exp_cnt + 5'd1) == exp_period);

  // Envelope / divider next values (applied only when CLKen is high).
  always_comb begin
    env_nx = env;
    exp_nx = exp_cnt;
    case (state)
      ATTACK: begin
        if (rate_tick && env != 8'hFF) env_nx = env + 8'd1;
      end
      DECAY_SUSTAIN: begin
        if (rate_tick) exp_nx = exp_tick ? 5'd0 : exp_cnt + 5'd1;
        if (exp_tick && env > sus_level) env_nx = env - 8'd1;
      end
      default: begin
        if (rate_tick) exp_nx = exp_tick ? 5'd0 : exp_cnt + 5'd1;
        if (exp_tick && env != 8'h00) env_nx = env - 8'd1;
      end
    endcase
  end

  // Gate edges win; attack hands over to decay on the edge that reaches 0xFF.
  always_comb begin
    state_nx = state;
    if (gate_rise)
      state_nx = ATTACK;
    else if (gate_fall)
      state_nx = RELEASE;
    else if (state == ATTACK && CLKen && env_nx == 8'hFF)
      state_nx = DECAY_SUSTAIN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RELEASE;
      gate     <= 1'b0;
      gate_q   <= 1'b0;
      atk      <= 4'h0;
      dcy      <= 4'h0;
      sus      <= 4'h0;
      rel      <= 4'h0;
      env      <= 8'h00;
      rate_cnt <= 15'd0;
      exp_cnt  <= 5'd0;
    end else begin
      if (WR) begin
        if (ADDR == CTRL_ADDR) gate <= DATA[0];
        if (ADDR == AD_ADDR) begin
          atk <= DATA[7:4];
          dcy <= DATA[3:0];
        end
        if (ADDR == SR_ADDR) begin
          sus <= DATA[7:4];
          rel <= DATA[3:0];
        end
      end
      gate_q <= gate;
      state  <= state_nx;
      if (CLKen) begin
        rate_cnt <= rate_nx;
        env      <= env_nx;
        exp_cnt  <= exp_nx;
      end
      if (gate_rise) exp_cnt <= 5'd0;
    end
  end

endmodule

// File: tb/tb_sid_envelope.sv
// Directed bench for sid_envelope: two instances share one write bus, one at
// BASE_ADDR 0x00 (u0) and one at 0x07 (u7), so address decode is observable.
module tb_sid_envelope;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CLKen = 1'b0;
  logic       WR = 1'b0;
  logic [4:0] ADDR = 5'h00;
  logic [7:0] DATA = 8'h00;
  logic [7:0] out0, out7;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  sid_envelope #(.BASE_ADDR(5'h00)) u0 (
    .CLK(CLK), .RST(RST), .CLKen(CLKen), .WR(WR),
    .ADDR(ADDR), .DATA(DATA), .OUTPUT(out0)
  );

  sid_envelope #(.BASE_ADDR(5'h07)) u7 (
    .CLK(CLK), .RST(RST), .CLKen(CLKen), .WR(WR),
    .ADDR(ADDR), .DATA(DATA), .OUTPUT(out7)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // One register write, then an idle clock so a gate edge gets evaluated.
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge CLK); WR = 1'b1; ADDR = a; DATA = d;
    @(negedge CLK); WR = 1'b0;
    @(negedge CLK);
  endtask

  // n CLKen pulses, one every 4th CLK.
  task automatic run4(input int n);
    repeat (n) begin
      @(negedge CLK); CLKen = 1'b1;
      @(negedge CLK); CLKen = 1'b0;
      repeat (2) @(negedge CLK);
    end
  endtask

  // n CLKen pulses on consecutive CLKs.
  task automatic runf(input int n);
    @(negedge CLK); CLKen = 1'b1;
    repeat (n) @(negedge CLK);
    CLKen = 1'b0;
  endtask

  logic [7:0] prev;

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_u0", out0, 8'h00);
    chk("reset_u7", out7, 8'h00);
    RST = 1'b0;

    // Attack to full at period 9: 255 * 9 = 2295 CLKen pulses.
    wr(5'h05, 8'h00);
    wr(5'h06, 8'hF0);
    wr(5'h04, 8'h01);
    run4(8);
    chk("atk_8", out0, 8'h00);
    run4(1);
    chk("atk_9", out0, 8'h01);
    repeat (50) @(negedge CLK);
    chk("clken_hold", out0, 8'h01);
    run4(567);
    chk("atk_576", out0, 8'h40);
    chk("u7_idle_a", out7, 8'h00);
    run4(1718);
    chk("atk_2294", out0, 8'hFE);
    run4(1);
    chk("atk_2295", out0, 8'hFF);
    runf(99);
    chk("sustain_ff", out0, 8'hFF);

    // Decay to sustain 0x88: 119 rate ticks at exp period 1.
    wr(5'h06, 8'h80);
    runf(1062);
    chk("decay_118", out0, 8'h89);
    runf(9);
    chk("decay_119", out0, 8'h88);
    runf(10008);
    chk("sustain_88", out0, 8'h88);
    chk("u7_idle_b", out7, 8'h00);

    // Release with rate 0; one rate tick = 9 CLKen pulses.
    wr(5'h04, 8'h00);
    prev = out0;
    for (int i = 1; i <= 737; i++) begin
      runf(9);
      chk("rel_mono", (out0 <= prev) ? 8'h01 : 8'h00, 8'h01);
      prev = out0;
      if (i == 43)  chk("rel_5d", out0, 8'h5D);
      if (i == 44)  chk("rel_5d_hold", out0, 8'h5D);
      if (i == 45)  chk("rel_5c", out0, 8'h5C);
      if (i == 457) chk("rel_06", out0, 8'h06);
      if (i == 636) chk("rel_01", out0, 8'h01);
      if (i == 637) chk("rel_00", out0, 8'h00);
    end
    chk("rel_floor", out0, 8'h00);

    // Reset mid-attack; the reset cycle also carries a gate write and CLKen.
    wr(5'h04, 8'h01);
    runf(576);
    chk("mid_atk_40", out0, 8'h40);
    @(negedge CLK); RST = 1'b1; WR = 1'b1; ADDR = 5'h04; DATA = 8'h01; CLKen = 1'b1;
    @(negedge CLK); RST = 1'b0; WR = 1'b0; CLKen = 1'b0;
    chk("rst_mid", out0, 8'h00);
    runf(27);
    chk("rst_no_gate", out0, 8'h00);
    wr(5'h04, 8'h01);
    runf(8);
    chk("restart_8", out0, 8'h00);
    runf(1);
    chk("restart_9", out0, 8'h01);
    chk("u7_idle_c", out7, 8'h00);

    // u7 responds only at 0x0B..0x0D; u0 keeps its own attack.
    wr(5'h0C, 8'h00);
    wr(5'h0D, 8'hF0);
    wr(5'h0B, 8'h01);
    runf(45);
    chk("u7_atk_5", out7, 8'h05);
    chk("u0_atk_6", out0, 8'h06);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
